calc_entry_ctrl: RTL

Keypad-side entry and sequencing controller for the calculator datapath. It turns debounced key strobes into the sign-magnitude operand buses and the control pulses the arithmetic block consumes: `V1`, `V2`, `opcode`, `newop`, `newhex` and `eq`. It also reads back that block's `answer` and overflow flag to chain operations left-to-right and to hold results. It sits between the keypad scanner/debouncer and the arithmetic block, and drives the display formatter.

---
 rtl/calc_entry_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/calc_entry_ctrl.sv
// Keypad entry and sequencing controller for the calculator datapath.
// Builds sign-magnitude operands from key strobes and chains results left-to-right.
module calc_entry_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  input  logic [16:0] answer,
  input  logic        ovw,
  output logic [16:0] V1,
  output logic [16:0] V2,
  output logic [1:0]  opcode,
  output logic        newop,
  output logic        newhex,
  output logic        eq,
  output logic [16:0] disp_value,
  output logic        err,
  output logic        ready
);

  localparam int unsigned MAG_W = 16;
  localparam int unsigned VAL_W = MAG_W + 1;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_MUL = 5'h11;
  localparam logic [4:0] K_SUB = 5'h12;
  localparam logic [4:0] K_EQ  = 5'h13;
  localparam logic [4:0] K_CLR = 5'h14;
  localparam logic [4:0] K_NEG = 5'h15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    OP_PEND = 3'd2,
    EQ_WAIT = 3'd3,
    RESULT  = 3'd4,
    ERROR   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VAL_W-1:0]   result_q, result_d;
  logic [VAL_W-1:0]   v1_d, v2_d, disp_d;
  logic [1:0]         op_d;
  logic               newop_d, newhex_d, eq_d, err_d, ready_d;

  logic is_digit, is_op, is_eq, is_clr, is_neg;
  logic [VAL_W-1:0] digit_val;

  // Key decode; unknown codes fall through every branch and are ignored.
  always_comb begin
    is_digit  = key_valid && !key_code[4];
    is_op     = key_valid && (key_code == K_ADD || key_code == K_MUL || key_code == K_SUB);
    is_eq     = key_valid && (key_code == K_EQ);
    is_clr    = key_valid && (key_code == K_CLR);
    is_neg    = key_valid && (key_code == K_NEG);
    digit_val = {1'b0, MAG_W'(key_code[3:0])};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    v1_d     = V1;
    v2_d     = V2;
    op_d     = opcode;
    err_d    = err;
    newop_d  = 1'b0;
    newhex_d = 1'b0;
    eq_d     = 1'b0;

    if (is_clr) begin
      v1_d    = '0;
      v2_d    = '0;
      op_d    = 2'b00;
      newop_d = 1'b1;
      err_d   = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ENTRY: begin
          if (is_digit) begin
            if (state_q == IDLE) begin
              v1_d     = digit_val;
              cnt_d    = CNT_W'(1);
              newhex_d = 1'b1;
              state_d  = ENTRY;
            end else if (cnt_q < CNT_W'(DIGITS)) begin
              v1_d     = {V1[VAL_W-1], V1[MAG_W-5:0], key_code[3:0]};
              cnt_d    = cnt_q + CNT_W'(1);
              newhex_d = 1'b1;
            end
          end else if (is_neg) begin
            if (state_q == ENTRY && V1[MAG_W-1:0] != '0) begin
              v1_d     = {~V1[VAL_W-1], V1[MAG_W-1:0]};
              newhex_d = 1'b1;
            end
          end else if (is_op) begin
            // Pending op is add with V2 = 0 after reset/clear, so answer is V1 here.
            if (ovw) begin
              err_d   = 1'b1;
              state_d = ERROR;
            end else begin
              v2_d    = answer;
              op_d    = key_code[1:0];
              newop_d = 1'b1;
              state_d = OP_PEND;
            end
          end else if (is_eq && state_q == ENTRY) begin
            eq_d    = 1'b1;
            state_d = EQ_WAIT;
          end
        end
        OP_PEND: begin
          if (is_digit) begin
            v1_d     = digit_val;
            cnt_d    = CNT_W'(1);
            newhex_d = 1'b1;
            state_d  = ENTRY;
          end else if (is_op) begin
            op_d    = key_code[1:0];
            newop_d = 1'b1;
          end
        end
        EQ_WAIT: begin
          if (ovw) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            result_d = answer;
            v2_d     = answer;
            v1_d     = '0;
            cnt_d    = '0;
            state_d  = RESULT;
          end
        end
        RESULT: begin
          if (is_digit) begin
            v1_d     = digit_val;
            v2_d     = '0;
            op_d     = 2'b00;
            cnt_d    = CNT_W'(1);
            newop_d  = 1'b1;
            newhex_d = 1'b1;
            state_d  = ENTRY;
          end else if (is_op) begin
            v1_d    = '0;
            op_d    = key_code[1:0];
            newop_d = 1'b1;
            state_d = OP_PEND;
          end
        end
        ERROR: begin
          err_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    case (state_d)
      IDLE, ENTRY: disp_d = v1_d;
      OP_PEND:     disp_d = v2_d;
      RESULT:      disp_d = result_d;
      EQ_WAIT:     disp_d = disp_value;
      default:     disp_d = '0;
    endcase

    ready_d = (state_d != EQ_WAIT);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      V1         <= '0;
      V2         <= '0;
      opcode     <= 2'b00;
      newop      <= 1'b0;
      newhex     <= 1'b0;
      eq         <= 1'b0;
      disp_value <= '0;
      err        <= 1'b0;
      ready      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      V1         <= v1_d;
      V2         <= v2_d;
      opcode     <= op_d;
      newop      <= newop_d;
      newhex     <= newhex_d;
      eq         <= eq_d;
      disp_value <= disp_d;
      err        <= err_d;
      ready      <= ready_d;
    end
  end

endmodule
